// File: rtl/wb_arb.sv
// -----------------------------------------------------------------------------
// wb_arb -- writeback arbiter in front of the 32x32 register file write port.
//
// Two result sources share the single register file write port:
//   * ALU path : one result per cycle, never back-pressured, highest priority.
//   * MDU path : multiply/divide/load results, queued in a small FIFO.
// A pending-write lookup lets decode stall on queued MDU results. A
// starvation hold stops sustained ALU traffic from blocking the FIFO head
// indefinitely.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   alu_valid/waddr/wdata ALU result (writes to $0 are dropped)
//   mdu_valid/waddr/wdata MDU result offer
//   mdu_ready             FIFO can accept (= !full, from count only)
//   q_addr, q_pending     decode lookup: a live queued write targets q_addr
//   alu_hold              registered; upstream keeps alu_valid low while set
//   rf_wen/waddr/wdata    registered register file write port
//
// Handshake: an MDU result transfers on a rising edge where mdu_valid and
// mdu_ready are both 1. mdu_ready depends only on the FIFO count, never on
// mdu_valid, and stays low while full even if the head pops that same edge.
// The producer must hold its offer until it transfers.
// -----------------------------------------------------------------------------
module wb_arb #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_waddr,
    input  logic [31:0] alu_wdata,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_waddr,
    input  logic [31:0] mdu_wdata,
    input  logic [4:0]  q_addr,
    output logic        q_pending,
    output logic        alu_hold,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    // Hold controller: ST_HOLD lasts exactly one cycle, during which the
    // FIFO head is forced out. alu_hold is a direct decode of this register.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } hold_state_t;

    hold_state_t state_q, state_d;

    // FIFO storage. An entry is "live" only while queued and not killed;
    // free slots are always dead so the lookup can scan every slot.
    logic [DEPTH-1:0] live_q, live_d;
    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [SW-1:0]    starve_q, starve_d;

    logic             empty;
    logic             full;
    logic             alu_eff;
    logic             alu_sel;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] kill;

    // ------------------------------------------------------------------
    // Selection
    // ------------------------------------------------------------------
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign mdu_ready = !full;
    assign alu_hold  = (state_q == ST_HOLD);

    assign alu_eff = alu_valid && (alu_waddr != 5'd0);
    assign alu_sel = alu_eff && (state_q == ST_RUN);
    assign push    = mdu_valid && !full;
    assign pop     = !alu_sel && !empty;

    // An ALU write is younger than everything queued, so any queued live
    // write to the same register is now stale and must never reach the
    // register file. The entry being pushed this edge is not in live_q yet,
    // so it is naturally exempt.
    always_comb begin
        kill = '0;
        if (alu_sel) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (live_q[i] && (addr_q[i] == alu_waddr)) begin
                    kill[i] = 1'b1;
                end
            end
        end
    end

    // Lookup over live slots; the head being popped this cycle still counts.
    always_comb begin
        q_pending = 1'b0;
        if (q_addr != 5'd0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (live_q[i] && (addr_q[i] == q_addr)) begin
                    q_pending = 1'b1;
                end
            end
        end
    end

    // Next liveness: apply kills, free the popped slot, then mark the
    // pushed slot. Push and pop never hit the same slot in one edge
    // (that would need the FIFO to be both empty and full).
    always_comb begin
        live_d = live_q & ~kill;
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            live_d[wr_ptr_q] = (mdu_waddr != 5'd0);
        end
    end

    // ------------------------------------------------------------------
    // Starvation / hold controller (next-state)
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            ST_HOLD: begin
                // The head is popped during the hold cycle; release next edge.
                state_d  = ST_RUN;
                starve_d = '0;
            end
            default: begin
                if (pop || empty) begin
                    starve_d = '0;
                end else begin
                    // Non-empty and not popping means the ALU won this edge.
                    starve_d = starve_q + STARVE_ONE;
                    if (starve_d == STARVE_LIM) begin
                        state_d = ST_HOLD;
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            starve_q <= '0;
            live_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            live_q   <= live_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload needs no reset: a slot is only read after it has been pushed,
    // and liveness (which is reset) decides whether it ever writes.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            addr_q[wr_ptr_q] <= mdu_waddr;
            data_q[wr_ptr_q] <= mdu_wdata;
        end
    end

    // Register file write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else if (alu_sel) begin
            rf_wen   <= 1'b1;
            rf_waddr <= alu_waddr;
            rf_wdata <= alu_wdata;
        end else if (pop) begin
            // A killed or $0 head drains silently: address/data still move.
            rf_wen   <= live_q[rd_ptr_q];
            rf_waddr <= addr_q[rd_ptr_q];
            rf_wdata <= data_q[rd_ptr_q];
        end else begin
            rf_wen   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arb.sv
// -----------------------------------------------------------------------------
// tb_wb_arb -- directed bench for wb_arb (DEPTH=2, STARVE_MAX=4).
// Each table row gives the inputs for one rising edge and the outputs
// expected just after that edge. Starvation and mid-operation reset are
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_wb_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_waddr;
    logic [31:0] mdu_wdata;
    logic [4:0]  q_addr;
    logic        q_pending;
    logic        alu_hold;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    wb_arb #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_waddr (alu_waddr),
        .alu_wdata (alu_wdata),
        .mdu_valid (mdu_valid),
        .mdu_ready (mdu_ready),
        .mdu_waddr (mdu_waddr),
        .mdu_wdata (mdu_wdata),
        .q_addr    (q_addr),
        .q_pending (q_pending),
        .alu_hold  (alu_hold),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic [4:0]  qa;
        logic        e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_rdy;
        logic        e_qp;
        logic        e_hold;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    function automatic vec_t mk(input logic r, input logic av, input logic [4:0] aa,
                                input logic [31:0] ad, input logic mv, input logic [4:0] ma,
                                input logic [31:0] md, input logic [4:0] qa,
                                input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                                input logic er, input logic eq, input logic eh);
        vec_t v;
        v.rst = r;  v.av = av; v.aa = aa; v.ad = ad;
        v.mv  = mv; v.ma = ma; v.md = md; v.qa = qa;
        v.e_wen = ew; v.e_waddr = ea; v.e_wdata = ed;
        v.e_rdy = er; v.e_qp = eq; v.e_hold = eh;
        return v;
    endfunction

    task automatic drive(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic [4:0] qa);
        @(negedge clk);
        rst = r; alu_valid = av; alu_waddr = aa; alu_wdata = ad;
        mdu_valid = mv; mdu_waddr = ma; mdu_wdata = md; q_addr = qa;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic ew, input logic [4:0] ea,
                             input logic [31:0] ed, input logic er, input logic eq,
                             input logic eh);
        check({tag, " rf_wen"},    32'(rf_wen),    32'(ew));
        check({tag, " rf_waddr"},  32'(rf_waddr),  32'(ea));
        check({tag, " rf_wdata"},  rf_wdata,       ed);
        check({tag, " mdu_ready"}, 32'(mdu_ready), 32'(er));
        check({tag, " q_pending"}, 32'(q_pending), 32'(eq));
        check({tag, " alu_hold"},  32'(alu_hold),  32'(eh));
    endtask

    initial begin
        int edges;

        rst = 1'b1; alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
        mdu_valid = 1'b0; mdu_waddr = '0; mdu_wdata = '0; q_addr = '0;

        //            rst av aa  ad            mv ma  md        qa   wen wa  wd            rdy qp hold
        // reset with handshakes that must be discarded
        tbl.push_back(mk(1, 1, 5'd3, 32'h1, 1, 5'd3, 32'h2, 5'd3,   0, 5'd0, 32'h0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 5'd0, 32'h0, 1, 5'd3, 32'h2, 5'd3,   0, 5'd0, 32'h0, 1, 0, 0));
        // idle for five cycles
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd7, 0, 5'd0, 32'h0, 1, 0, 0));
        // ALU write, one cycle, then ALU write to $0 dropped
        tbl.push_back(mk(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 5'd5, 1, 5'd5, 32'hDEADBEEF, 1, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd5,   0, 5'd5, 32'hDEADBEEF, 1, 0, 0));
        tbl.push_back(mk(0, 1, 5'd0, 32'h11111111, 0, 5'd0, 32'h0, 5'd0, 0, 5'd5, 32'hDEADBEEF, 1, 0, 0));
        // MDU into empty arbiter: pending after N, written after N+1
        tbl.push_back(mk(0, 0, 5'd0, 32'h0, 1, 5'd7, 32'h12, 5'd7,  0, 5'd5, 32'hDEADBEEF, 1, 1, 0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd7,   1, 5'd7, 32'h12, 1, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd7,   0, 5'd7, 32'h12, 1, 0, 0));
        // full FIFO under ALU traffic to 9; third offer (5) refused; hold after 4
        tbl.push_back(mk(0, 1, 5'd9, 32'h901, 1, 5'd3, 32'h33, 5'd3, 1, 5'd9, 32'h901, 1, 1, 0));
        tbl.push_back(mk(0, 1, 5'd9, 32'h902, 1, 5'd4, 32'h44, 5'd4, 1, 5'd9, 32'h902, 0, 1, 0));
        tbl.push_back(mk(0, 1, 5'd9, 32'h903, 1, 5'd5, 32'h55, 5'd5, 1, 5'd9, 32'h903, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5'd9, 32'h904, 1, 5'd5, 32'h55, 5'd3, 1, 5'd9, 32'h904, 0, 1, 0));
        tbl.push_back(mk(0, 1, 5'd9, 32'h905, 1, 5'd5, 32'h55, 5'd4, 1, 5'd9, 32'h905, 0, 1, 1));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,   0, 5'd0, 32'h0,  5'd3, 1, 5'd3, 32'h33,  1, 0, 0));
        tbl.push_back(mk(0, 1, 5'd9, 32'h907, 0, 5'd0, 32'h0,  5'd4, 1, 5'd9, 32'h907, 1, 1, 0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,   0, 5'd0, 32'h0,  5'd4, 1, 5'd4, 32'h44,  1, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,   0, 5'd0, 32'h0,  5'd0, 0, 5'd4, 32'h44,  1, 0, 0));
        // kill: queued 6/AA overtaken by ALU 6/BB, drains with rf_wen=0
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,  1, 5'd6, 32'hAA, 5'd6, 0, 5'd4, 32'h44, 1, 1, 0));
        tbl.push_back(mk(0, 1, 5'd6, 32'hBB, 0, 5'd0, 32'h0,  5'd6, 1, 5'd6, 32'hBB, 1, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd6, 0, 5'd6, 32'hAA, 1, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd6, 0, 5'd6, 32'hAA, 1, 0, 0));
        // kill with same-address push in the ALU edge: new entry survives
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,  1, 5'd8, 32'h81, 5'd8, 0, 5'd6, 32'hAA, 1, 1, 0));
        tbl.push_back(mk(0, 1, 5'd8, 32'h82, 1, 5'd8, 32'h83, 5'd8, 1, 5'd8, 32'h82, 0, 1, 0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd8, 0, 5'd8, 32'h81, 1, 1, 0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd8, 1, 5'd8, 32'h83, 1, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd8, 0, 5'd8, 32'h83, 1, 0, 0));
        // simultaneous push and pop
        tbl.push_back(mk(0, 0, 5'd0, 32'h0, 1, 5'd10, 32'hA0, 5'd10, 0, 5'd8,  32'h83, 1, 1, 0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0, 1, 5'd11, 32'hB0, 5'd10, 1, 5'd10, 32'hA0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0,  32'h0,  5'd11, 1, 5'd11, 32'hB0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0,  32'h0,  5'd11, 0, 5'd11, 32'hB0, 1, 0, 0));
        // MDU push to $0: accepted, stored dead, drains silently
        tbl.push_back(mk(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h77, 5'd0, 0, 5'd11, 32'hB0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  5'd0, 0, 5'd0,  32'h77, 1, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  5'd0, 0, 5'd0,  32'h77, 1, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].av, tbl[i].aa, tbl[i].ad,
                  tbl[i].mv, tbl[i].ma, tbl[i].md, tbl[i].qa);
            edge_wait();
            check_all($sformatf("row%0d", i), tbl[i].e_wen, tbl[i].e_waddr, tbl[i].e_wdata,
                      tbl[i].e_rdy, tbl[i].e_qp, tbl[i].e_hold);
        end

        // Starvation: one queued entry, ALU hammers register 9 until the hold
        // rises. The head is pushed on an empty FIFO, so STARVE_MAX further
        // ALU-selected edges are needed.
        drive(0, 1, 5'd9, 32'h1000, 1, 5'd20, 32'h2020, 5'd20);
        edge_wait();
        check("starve first alu", rf_wdata, 32'h1000);
        check("starve pending", 32'(q_pending), 32'd1);
        edges = 0;
        for (int k = 1; k <= 10 && !alu_hold; k++) begin
            drive(0, 1, 5'd9, 32'h1000 + 32'(k), 0, 5'd0, 32'h0, 5'd20);
            exp_q.push_back(32'h1000 + 32'(k));
            edge_wait();
            edges++;
            check($sformatf("starve alu %0d", k), rf_wdata, exp_q.pop_front());
        end
        check("starve hold raised", 32'(alu_hold), 32'd1);
        check("starve edges", 32'(edges), 32'd4);
        exp_q.push_back(32'h2020);
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd20);
        edge_wait();
        check("starve drain wen", 32'(rf_wen), 32'd1);
        check("starve drain addr", 32'(rf_waddr), 32'd20);
        check("starve drain data", rf_wdata, exp_q.pop_front());
        check("starve hold dropped", 32'(alu_hold), 32'd0);
        check("starve pending clear", 32'(q_pending), 32'd0);

        // Reset mid-operation with two entries queued.
        drive(0, 1, 5'd1, 32'h1, 1, 5'd12, 32'hC1, 5'd12);
        edge_wait();
        drive(0, 1, 5'd2, 32'h2, 1, 5'd13, 32'hC2, 5'd12);
        edge_wait();
        check("midrst full", 32'(mdu_ready), 32'd0);
        check("midrst pending", 32'(q_pending), 32'd1);
        drive(1, 1, 5'd3, 32'h3, 1, 5'd14, 32'hC3, 5'd12);
        edge_wait();
        check_all("midrst", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, (k % 2 == 0) ? 5'd13 : 5'd14);
            edge_wait();
            check($sformatf("midrst idle%0d wen", k), 32'(rf_wen), 32'd0);
            check($sformatf("midrst idle%0d pending", k), 32'(q_pending), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
